store_drain_ctrl: RTL and testbench
===================================

Name: store_drain_ctrl

Overview:
- Sits between the retire stage and the data-cache write port.
- Each retiring store hands its committed address/data/size to this block; the block queues it in an in-order FIFO and drains it to memory through a req/ack handshake, one store at a time.
- Drives the retire-stage stall when the FIFO cannot accept another store, so retire never loses a committed store.
- Committed stores survive pipeline flushes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 64, address width.
- DATA_W, 64, store data width (one MemoryWord).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- commit_valid  in  1  retire is committing a store this cycle (lsq_decrement of a store).
- commit_addr  in  ADDR_W  store address.
- commit_data  in  DATA_W  store data, right-aligned.
- commit_size  in  4  byte count: 1, 2, 4 or 8.
- flush  in  1  pipeline flush; has no effect on queued entries.
- mem_req  out  1  write request to the data cache.
- mem_addr  out  ADDR_W  head entry address.
- mem_data  out  DATA_W  head entry data.
- mem_size  out  4  head entry size.
- mem_ack  in  1  cache accepted the write this cycle.
- retire_stall  out  1  FIFO full; retire must not commit.
- drain_busy  out  1  FIFO non-empty or a request is outstanding.
- count  out  $clog2(DEPTH+1)  occupied entries.
- err  out  1  sticky: a store was pushed while full, or had an illegal size.

Behaviour:
- Reset (async, active-high):
  - FIFO empty: count=0, head and tail pointers 0.
  - State IDLE.
  - mem_req=0; mem_addr, mem_data and mem_size = 0; retire_stall=0; drain_busy=0; err=0.
- Storage:
  - Circular FIFO with pointers of width $clog2(DEPTH) that wrap naturally.
  - count is a registered value tracked separately from the pointers.
- Push:
  - Occurs when commit_valid=1 and count<DEPTH, sampled on clk.
  - An entry pushed in cycle N is visible at the FIFO head no earlier than cycle N+1. Push-to-mem_req latency is 1 cycle when the FIFO was empty.
- Illegal size (commit_size not in {1,2,4,8}): the entry is not written and err is set.
- Push while full (count==DEPTH): the entry is dropped and err is set. This is a protocol violation, because retire_stall was already high.
- FSM:
  - IDLE: mem_req=0. Go to REQ when count>0.
  - REQ: mem_req=1, with mem_addr, mem_data and mem_size driven from the head entry.
    - On mem_ack the head is popped.
    - If count after the pop is >0, stay in REQ with the next entry (back-to-back, no bubble).
    - Otherwise go to IDLE.
- Stability: while mem_req=1 and mem_ack=0, mem_addr, mem_data and mem_size are held stable across cycles.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal even when count==DEPTH, but retire_stall is still 1 that cycle.
- retire_stall = (count==DEPTH), decoded from the registered count only, with no combinational path from mem_ack. One cycle of stall follows the pop that frees an entry.
- drain_busy = (count!=0).
- flush: ignored by the storage and the FSM. Committed stores always drain.
- err: cleared only by reset.

Optional Feature:
- Macro: STORE_DRAIN_FWD_EN.
- When defined, the block adds the following ports:
  - ld_addr  in  ADDR_W
  - ld_size  in  4
  - fwd_hit  out  1
  - fwd_data  out  DATA_W
- Forwarding rule:
  - fwd_hit=1, combinationally, when any valid entry has addr==ld_addr and size==ld_size.
  - fwd_data is the youngest such entry's data.
  - A partial overlap gives fwd_hit=0.
- When the macro is not defined, these ports and the compare logic are absent. The rest of the behaviour is identical.

Decomposition:
- Shared package gains:
  - typedef store_drain_entry, containing addr, data and size.
  - enum drain_state_t {IDLE, REQ}.
  - Size constants SZ_B=1, SZ_H=2, SZ_W=4, SZ_D=8.
- One sub-module: store_drain_fifo, a generic circular FIFO holding push/pop/count/full/empty.
- The controller FSM, error logic and forwarding compare stay in store_drain_ctrl.

Test Plan:
- Single store: push addr=0x100, data=0xDEADBEEF, size=4 in cycle 0 → mem_req=1 in cycle 1 with those values; mem_ack in cycle 3 → mem_req=0 in cycle 4, drain_busy=0.
- Fill: push 4 stores on consecutive cycles with mem_ack held 0 → count=4 and retire_stall=1 after the 4th. A 5th push sets err=1, and count stays 4.
- Back-to-back drain: 3 queued entries with mem_ack=1 every cycle → mem_req stays high for 3 consecutive cycles, showing entries 0, 1, 2 in order, then IDLE.
- Simultaneous push and pop at count=4 → count stays 4, retire_stall=1, and order is preserved (verify by data sequence 0x1..0x5).
- Flush and reset: flush=1 with 2 entries queued → both still drain. Asserting reset mid-REQ → all outputs are 0 asynchronously and the FIFO is empty after release.
- With STORE_DRAIN_FWD_EN defined: entries (0x200, 0xAA, 8) then (0x200, 0xBB, 8); ld_addr=0x200, ld_size=8 → fwd_hit=1, fwd_data=0xBB. With ld_size=4 → fwd_hit=0.

Source files
------------

// File: rtl/store_drain_pkg.sv
// Shared types and constants for the store drain controller: the queued
// entry layout, the drain FSM states and the legal store sizes.
package store_drain_pkg;

    localparam int SD_ADDR_W = 64;
    localparam int SD_DATA_W = 64;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;

    // Entry layout at the default widths; the controller builds the same
    // layout at its own parameterised widths.
    typedef struct packed {
        logic [SD_ADDR_W-1:0] addr;
        logic [SD_DATA_W-1:0] data;
        logic [3:0]           size;
    } store_drain_entry;

    function automatic logic size_legal(input logic [3:0] sz);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W) || (sz == SZ_D);
    endfunction

endpackage

// File: rtl/store_drain_fifo.sv
// Generic in-order circular FIFO with a registered occupancy count kept
// separately from the pointers. A push is accepted while full only when a
// pop happens in the same cycle.
// Optional macro STORE_DRAIN_FWD_EN exposes the head pointer and the raw
// storage so the owner can search queued entries.
module store_drain_fifo
    import store_drain_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
`ifdef STORE_DRAIN_FWD_EN
    ,
    output logic [PTR_W-1:0]          head_o,
    output logic [DEPTH-1:0][W-1:0]   entries_o
`endif
);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

`ifdef STORE_DRAIN_FWD_EN
    assign head_o    = rd_ptr_q;
    assign entries_o = mem_q;
`endif

    // Occupancy follows accepted pushes and pops; unchanged when both occur.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers and count; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; only slots below the count are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/store_drain_ctrl.sv
// Store drain controller: queues committed stores in order and writes them
// to the data cache one at a time over a req/ack handshake. Flushes never
// touch queued stores. Optional macro STORE_DRAIN_FWD_EN adds a
// store-to-load forwarding search over the queued entries.
//
//   state | meaning
//   IDLE  | nothing to drain, mem_req low
//   REQ   | head entry presented on mem_*, waiting for mem_ack
module store_drain_ctrl
    import store_drain_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = SD_ADDR_W,
    parameter  int DATA_W = SD_DATA_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] commit_addr,
    input  logic [DATA_W-1:0] commit_data,
    input  logic [3:0]        commit_size,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [3:0]        mem_size,
    input  logic              mem_ack,
    output logic              retire_stall,
    output logic              drain_busy,
    output logic [CNT_W-1:0]  count,
    output logic              err
`ifdef STORE_DRAIN_FWD_EN
    ,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [3:0]        ld_size,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        size;
    } entry_t;

    localparam int W = $bits(entry_t);

    drain_state_t     state_q, state_d;
    logic             err_q, err_d;
    entry_t           wr_entry, head_entry;
    logic [CNT_W-1:0] count_q, count_next;
    logic             full, empty;
    logic             legal, pop, push;
    logic             unused_flush;

    // Flush is deliberately ignored: committed stores always drain.
    assign unused_flush = flush;

    assign wr_entry.addr = commit_addr;
    assign wr_entry.data = commit_data;
    assign wr_entry.size = commit_size;

    assign legal = size_legal(commit_size);
    assign pop   = (state_q == REQ) && mem_ack;
    assign push  = commit_valid && legal && (!full || pop);

    // Occupancy as it will be after this edge; lets IDLE launch the request
    // the cycle right after the first push.
    assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

`ifdef STORE_DRAIN_FWD_EN
    logic [PTR_W-1:0]        fwd_head;
    logic [DEPTH-1:0][W-1:0] fwd_entries;
    logic [PTR_W-1:0]        fwd_idx;
    entry_t                  fwd_e;
`endif

    store_drain_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (reset),
        .push_i    (push),
        .wdata_i   (wr_entry),
        .pop_i     (pop),
        .rdata_o   (head_entry),
        .count_o   (count_q),
        .full_o    (full),
        .empty_o   (empty)
`ifdef STORE_DRAIN_FWD_EN
        ,
        .head_o    (fwd_head),
        .entries_o (fwd_entries)
`endif
    );

    // Next-state and handshake outputs; mem_* are zero outside REQ.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        mem_size = '0;
        unique case (state_q)
            IDLE: begin
                if (count_next != '0) state_d = REQ;
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = head_entry.addr;
                mem_data = head_entry.data;
                mem_size = head_entry.size;
                if (count_next == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky error: illegal size, or a push into a full queue with no pop.
    always_comb begin
        err_d = err_q;
        if (commit_valid && (!legal || (full && !pop))) err_d = 1'b1;
    end

    // State and error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign retire_stall = full;
    assign drain_busy   = !empty;
    assign count        = count_q;
    assign err          = err_q;

`ifdef STORE_DRAIN_FWD_EN
    // Scan oldest to youngest so the last exact match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        fwd_e    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = fwd_head + PTR_W'(k);
            fwd_e   = fwd_entries[fwd_idx];
            if ((CNT_W'(k) < count_q) && (fwd_e.addr == ld_addr) && (fwd_e.size == ld_size)) begin
                fwd_hit  = 1'b1;
                fwd_data = fwd_e.data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl: a vector table for the main flows
// plus hand sequences for push-while-full, async reset and forwarding.
module tb_store_drain_ctrl;

    logic        clk;
    logic        reset;
    logic        commit_valid;
    logic [63:0] commit_addr;
    logic [63:0] commit_data;
    logic [3:0]  commit_size;
    logic        flush;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic [3:0]  mem_size;
    logic        mem_ack;
    logic        retire_stall;
    logic        drain_busy;
    logic [2:0]  count;
    logic        err;
`ifdef STORE_DRAIN_FWD_EN
    logic [63:0] ld_addr;
    logic [3:0]  ld_size;
    logic        fwd_hit;
    logic [63:0] fwd_data;
`endif

    int tests = 0;
    int fails = 0;

    store_drain_ctrl #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data),
        .commit_size  (commit_size),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_size     (mem_size),
        .mem_ack      (mem_ack),
        .retire_stall (retire_stall),
        .drain_busy   (drain_busy),
        .count        (count),
        .err          (err)
`ifdef STORE_DRAIN_FWD_EN
        ,
        .ld_addr      (ld_addr),
        .ld_size      (ld_size),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [63:0] addr;
        logic [63:0] data;
        logic [3:0]  size;
        logic        ack;
        logic        fl;
        logic        req;
        logic [63:0] maddr;
        logic [63:0] mdata;
        logic [3:0]  msize;
        logic [2:0]  cnt;
        logic        stall;
        logic        busy;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic cv, input logic [63:0] a, input logic [63:0] d,
                                input logic [3:0] s, input logic ack, input logic fl,
                                input logic req, input logic [63:0] ma, input logic [63:0] md,
                                input logic [3:0] ms, input logic [2:0] c, input logic st,
                                input logic b, input logic e);
        vec_t v;
        v.cv = cv; v.addr = a; v.data = d; v.size = s; v.ack = ack; v.fl = fl;
        v.req = req; v.maddr = ma; v.mdata = md; v.msize = ms; v.cnt = c;
        v.stall = st; v.busy = b; v.er = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [63:0] a, input logic [63:0] d,
                         input logic [3:0] s, input logic ack, input logic fl);
        commit_valid = cv; commit_addr = a; commit_data = d; commit_size = s;
        mem_ack = ack; flush = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
`ifdef STORE_DRAIN_FWD_EN
        ld_addr = '0;
        ld_size = '0;
`endif

        //          cv addr   data         sz ack fl | req maddr  mdata        ms cnt st bz er
        // single store, ack two cycles after the request rises
        vecs.push_back(mk(1, 64'h100, 64'hDEADBEEF, 4, 0, 0,  0, 0,      0,           0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,      0,            0, 0, 0,  1, 64'h100, 64'hDEADBEEF, 4, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,            0, 0, 0,  1, 64'h100, 64'hDEADBEEF, 4, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,            0, 1, 0,  1, 64'h100, 64'hDEADBEEF, 4, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,            0, 0, 0,  0, 0,      0,           0, 0, 0, 0, 0));
        // fill to four with no ack
        vecs.push_back(mk(1, 64'h10, 64'h1, 8, 0, 0,  0, 0,     0,     0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 64'h18, 64'h2, 8, 0, 0,  1, 64'h10, 64'h1, 8, 1, 0, 1, 0));
        vecs.push_back(mk(1, 64'h20, 64'h3, 8, 0, 0,  1, 64'h10, 64'h1, 8, 2, 0, 1, 0));
        vecs.push_back(mk(1, 64'h28, 64'h4, 8, 0, 0,  1, 64'h10, 64'h1, 8, 3, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0, 0, 0,  1, 64'h10, 64'h1, 8, 4, 1, 1, 0));
        // push and pop together while full, then back-to-back drain with flush asserted
        vecs.push_back(mk(1, 64'h30, 64'h5, 8, 1, 0,  1, 64'h10, 64'h1, 8, 4, 1, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0, 1, 0,  1, 64'h18, 64'h2, 8, 4, 1, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0, 1, 0,  1, 64'h20, 64'h3, 8, 3, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0, 1, 1,  1, 64'h28, 64'h4, 8, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0, 1, 1,  1, 64'h30, 64'h5, 8, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0, 0, 0,  0, 0,      0,     0, 0, 0, 0, 0));
        // two stores queued under flush still drain
        vecs.push_back(mk(1, 64'h40, 64'h6, 2, 0, 1,  0, 0,      0,     0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 64'h44, 64'h7, 1, 0, 1,  1, 64'h40, 64'h6, 2, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0, 0, 1,  1, 64'h40, 64'h6, 2, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0, 1, 0,  1, 64'h40, 64'h6, 2, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0, 1, 0,  1, 64'h44, 64'h7, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0, 0, 0,  0, 0,      0,     0, 0, 0, 0, 0));
        // illegal size: not queued, err becomes sticky
        vecs.push_back(mk(1, 64'h50, 64'h8, 3, 0, 0,  0, 0,      0,     0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,      0,     0, 0, 0,  0, 0,      0,     0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,      0,     0, 0, 0,  0, 0,      0,     0, 0, 0, 0, 1));

        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cv, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].ack, vecs[i].fl);
            #1;
            chk($sformatf("v%0d mem_req", i),      mem_req,      vecs[i].req);
            chk($sformatf("v%0d mem_addr", i),     mem_addr,     vecs[i].maddr);
            chk($sformatf("v%0d mem_data", i),     mem_data,     vecs[i].mdata);
            chk($sformatf("v%0d mem_size", i),     mem_size,     vecs[i].msize);
            chk($sformatf("v%0d count", i),        count,        vecs[i].cnt);
            chk($sformatf("v%0d retire_stall", i), retire_stall, vecs[i].stall);
            chk($sformatf("v%0d drain_busy", i),   drain_busy,   vecs[i].busy);
            chk($sformatf("v%0d err", i),          err,          vecs[i].er);
            @(negedge clk);
        end

        // push while full: fifth store dropped, err set, order intact
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1, 64'h80 + 64'(i), 64'h10 + 64'(i), 8, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("full count", count, 4);
        chk("full stall", retire_stall, 1);
        chk("full err", err, 1);
        begin
            logic [63:0] seen[$];
            for (int c = 0; c < 10 && seen.size() < 5; c++) begin
                @(negedge clk);
                mem_ack = 1'b1;
                #1;
                if (mem_req) seen.push_back(mem_data);
                else if (seen.size() > 0) break;
            end
            mem_ack = 1'b0;
            chk("drain length", 64'(seen.size()), 4);
            for (int k = 0; k < seen.size() && k < 4; k++)
                chk($sformatf("drain order %0d", k), seen[k], 64'h11 + 64'(k));
        end
        begin
            bit done = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (!drain_busy) begin done = 1; break; end
            end
            chk("drain idle within bound", 64'(done), 1);
        end

        // async reset in the middle of a request
        drive(1, 64'h300, 64'h33, 4, 0, 0);
        @(negedge clk);
        drive(1, 64'h308, 64'h34, 4, 0, 0);
        #1;
        chk("pre-reset req", mem_req, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async req", mem_req, 0);
        chk("async addr", mem_addr, 0);
        chk("async data", mem_data, 0);
        chk("async size", mem_size, 0);
        chk("async count", count, 0);
        chk("async busy", drain_busy, 0);
        chk("async err", err, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post-reset count", count, 0);
        chk("post-reset req", mem_req, 0);

`ifdef STORE_DRAIN_FWD_EN
        do_reset();
        drive(1, 64'h200, 64'hAA, 8, 0, 0);
        @(negedge clk);
        drive(1, 64'h200, 64'hBB, 8, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        ld_addr = 64'h200;
        ld_size = 4'd8;
        #1;
        chk("fwd hit", fwd_hit, 1);
        chk("fwd data youngest", fwd_data, 64'hBB);
        ld_size = 4'd4;
        #1;
        chk("fwd partial miss", fwd_hit, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
